// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit hex 7-segment driver
// Double-buffered display value swaps only at frame boundaries so a digit never tears.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]          digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]   act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic                      pending_q, pending_d;
    logic                      frame_done_q, frame_done_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    logic                      slot_end;
    logic                      frame_end;
    logic [NUM_DIGITS-1:0]     blank;
    logic                      zero_above;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [6:0]                seg_raw;
    logic [NUM_DIGITS-1:0]     an_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'b1111110;
            4'h1:    hex_to_seg = 7'b0110000;
            4'h2:    hex_to_seg = 7'b1101101;
            4'h3:    hex_to_seg = 7'b1111001;
            4'h4:    hex_to_seg = 7'b0110011;
            4'h5:    hex_to_seg = 7'b1011011;
            4'h6:    hex_to_seg = 7'b1011111;
            4'h7:    hex_to_seg = 7'b1110000;
            4'h8:    hex_to_seg = 7'b1111111;
            4'h9:    hex_to_seg = 7'b1111011;
            4'hA:    hex_to_seg = 7'b1110111;
            4'hB:    hex_to_seg = 7'b0011111;
            4'hC:    hex_to_seg = 7'b1001110;
            4'hD:    hex_to_seg = 7'b0111101;
            4'hE:    hex_to_seg = 7'b1001111;
            default: hex_to_seg = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        slot_end    = (div_cnt_q == CNT_W'(CLK_DIV - 1));
        frame_end   = slot_end && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
        end
        frame_done_d = frame_end;

        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pending_d  = pending_q;
        // A load landing on the boundary bypasses the pending buffer entirely.
        if (frame_end && load) begin
            act_val_d = value;
            act_dp_d  = dp_in;
            pending_d = 1'b0;
        end else if (frame_end && pending_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pending_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (act_val_q[i*4 +: 4] == 4'h0);
            blank[i]   = blank_lz & zero_above;
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_raw    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                cur_nib   = act_val_q[i*4 +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = blank[i];
                an_raw[i] = 1'b1;
            end
        end
        seg_raw = cur_blank ? 7'b0000000 : hex_to_seg(cur_nib);

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (enable) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dp_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
            an_d  = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111;
    localparam logic [6:0] SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111, SF = 7'b1000111;
    localparam logic [6:0] SX = 7'b0000000;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [7];

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_frame_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (frame_done) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n == 0) begin
            failures++;
            $display("FAIL frame_done_timeout: got none expected pulse within 40 cycles");
        end
    endtask

    // Entered at the negedge where frame_done is high; leaves at the next such negedge.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] exp_an;
                exp_an = ~(4'b0001 << d);
                step(1);
                chk({name, "_an"}, 32'(an), 32'(exp_an));
                chk({name, "_seg"}, 32'(seg), 32'(segs[d*7 +: 7]));
                chk({name, "_dp"}, 32'(dp), 32'(dps[d]));
                chk({name, "_frame_done"}, 32'(frame_done), 32'((d == 3) && (c == 3)));
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = {16'h0050, 4'b0000, 1'b1, SX, SX, S5, S0};
        vecs[1] = {16'h0000, 4'b0000, 1'b1, SX, SX, SX, S0};
        vecs[2] = {16'h0000, 4'b0000, 1'b0, S0, S0, S0, S0};
        vecs[3] = {16'h3456, 4'b1001, 1'b0, S3, S4, S5, S6};
        vecs[4] = {16'h789B, 4'b0000, 1'b0, S7, S8, S9, SB};
        vecs[5] = {16'hCDE0, 4'b0000, 1'b1, SC, SD, SE, S0};
        vecs[6] = {16'h0102, 4'b1000, 1'b1, SX, S1, S0, S2};

        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
        step(3);
        chk("reset_an", 32'(an), 32'h0000000f);
        chk("reset_seg", 32'(seg), 32'h0);
        chk("reset_dp", 32'(dp), 32'h0);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);

        rst_n = 1'b1;
        wait_frame_done(n);
        chk("first_frame_len", 32'(n), 32'd16);
        check_frame("idle", {S0, S0, S0, S0}, 4'b0000);

        // Mid-frame load stays pending until the boundary.
        step(5);
        pulse_load(16'h12AF, 4'b0100);
        chk("pend_set", 32'(pending), 32'h1);
        chk("pend_seg_unchanged", 32'(seg), 32'(S0));
        wait_frame_done(n);
        chk("pend_wait_len", 32'(n), 32'd10);
        check_frame("load12af", {S1, S2, SA, SF}, 4'b0100);
        chk("pend_clear", 32'(pending), 32'h0);

        for (int v = 0; v < 7; v++) begin
            blank_lz = vecs[v].blz;
            pulse_load(vecs[v].value, vecs[v].dp);
            wait_frame_done(n);
            check_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dp);
        end
        blank_lz = 1'b0;

        // Last load in a frame wins.
        pulse_load(16'h1111, 4'b0000);
        step(3);
        pulse_load(16'h2222, 4'b0000);
        wait_frame_done(n);
        check_frame("two_loads", {S2, S2, S2, S2}, 4'b0000);

        // Load exactly on the frame_end cycle goes straight to active.
        step(15);
        value = 16'hABCD; dp_in = 4'b0001; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("fe_load_frame_done", 32'(frame_done), 32'h1);
        chk("fe_load_pending", 32'(pending), 32'h0);
        check_frame("fe_load", {SA, SB, SC, SD}, 4'b0001);

        // Disable for 8 clocks; scan resumes where the free-running counter is.
        step(2);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("dis_an", 32'(an), 32'h0000000f);
            chk("dis_seg", 32'(seg), 32'h0);
            chk("dis_dp", 32'(dp), 32'h0);
        end
        enable = 1'b1;
        step(1);
        chk("resume_an", 32'(an), 32'b1011);
        chk("resume_seg", 32'(seg), 32'(SB));
        wait_frame_done(n);
        chk("resume_wait_len", 32'(n), 32'd5);
        check_frame("resume", {SA, SB, SC, SD}, 4'b0001);

        // Reset mid-frame with a pending load.
        step(3);
        pulse_load(16'h5555, 4'b1111);
        chk("rst_pend_set", 32'(pending), 32'h1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_an", 32'(an), 32'h0000000f);
        chk("rst_mid_seg", 32'(seg), 32'h0);
        chk("rst_mid_dp", 32'(dp), 32'h0);
        chk("rst_mid_pending", 32'(pending), 32'h0);
        chk("rst_mid_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        wait_frame_done(n);
        chk("rst_frame_len", 32'(n), 32'd16);
        check_frame("post_rst", {S0, S0, S0, S0}, 4'b0000);
        chk("post_rst_pending", 32'(pending), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
